beam_scan: RTL
==============

# beam_scan

Parametrised delay-and-sum beam scanner: successor to the fixed 4-mic/37-beam weight block. After the frequency detector reports a peak bin, it captures each channel's complex FFT value at that bin. For every steering beam it forms the sum over channels of delay coefficient × spectrum and the power |sum|². It reports the strongest beam, its angle and its power, plus a no-source flag against a runtime threshold. It sits between the FFT RAMs / delay-coefficient ROM and the angle display.

## Interface
- NUM_MICS, 4, channel count (≥2)
- NUM_BEAMS, 37, steering beams scanned (≥1)
- DATA_W, 14, width of each signed real/imag component (spectrum and coefficient)
- BIN_W, 10, FFT bin address width
- ANG_START, -90, signed angle of beam 0 (degrees)
- ANG_STEP, 5, degrees between adjacent beams
- ACC_W = 2*DATA_W+1+clog2(NUM_MICS); PWR_W = 2*ACC_W+1 (derived)

- clk  in  1  system clock
- KEY  in  4  KEY[0] = reset, synchronous, active-low; KEY[3:1] unused
- start  in  1  pulse from freqdetect done; sampled only in IDLE
- maxbin  in  BIN_W  bin to beamform; sampled with start
- thresh  in  PWR_W  unsigned minimum power for a valid source
- spec_addr  out  BIN_W  FFT RAM read address
- spec_ch  out  clog2(NUM_MICS)  channel select for the FFT RAM read mux
- spec_q  in  2*DATA_W  {re,im}, 1-cycle read latency
- coef_addr  out  clog2(NUM_BEAMS*NUM_MICS)  = beam*NUM_MICS + mic
- coef_q  in  2*DATA_W  {re,im}, 1-cycle read latency
- busy  out  1  high from the cycle after start acceptance through DONE
- done  out  1  single-cycle pulse when results update
- bnum  out  clog2(NUM_BEAMS)  best beam index
- doa  out  8 signed  ANG_START + ANG_STEP*bnum
- best_pwr  out  PWR_W  power of the best beam
- no_source  out  1  best_pwr < thresh

## Operation
- States: IDLE, LOAD, ACCUM, POWER, COMPARE, DONE.
- IDLE: when start=1, latch maxbin to spec_addr, clear best power/index, go to LOAD. start is ignored in all other states.
- LOAD: issue spec_ch = 0..NUM_MICS-1 on consecutive cycles. Capture spec_q into local buffer[ch] one cycle after issue. NUM_MICS+1 cycles, then go to ACCUM with beam=0 and acc=0.
- ACCUM: issue coef_addr for mic m = 0..NUM_MICS-1 on consecutive cycles. One cycle later, add product(coef_q, buffer[m]) to acc_re/acc_im. NUM_MICS+1 cycles per beam.
- Complex product: re = cr*sr − ci*si; im = cr*si + ci*sr. Operands signed. Full precision to 2*DATA_W+1 bits, sign-extended to ACC_W. No truncation and no overflow possible.
- POWER: register pwr = acc_re² + acc_im² (unsigned PWR_W).
- COMPARE: if pwr > best_pwr, or this is beam 0, update best_pwr and best index. Strict > means a tie keeps the lower beam index. If beam = NUM_BEAMS-1, go to DONE; else increment beam, clear acc, go to ACCUM.
- DONE: load bnum, doa, best_pwr and no_source from the internal best values. Pulse done. Go to IDLE.
- Outputs hold their values between done pulses.

## Timing
- All outputs reset to 0. On reset: state=IDLE, busy=0, done=0, no_source=0.
- Reset is synchronous and has priority in every state, including mid-scan. A scan in progress is discarded and outputs return to 0.
- Call the start-sampling cycle 0. LOAD runs cycles 1..NUM_MICS+1. Beam b occupies NUM_MICS+3 cycles starting at cycle NUM_MICS+2+b*(NUM_MICS+3).
- done is high in cycle T = NUM_MICS+2+NUM_BEAMS*(NUM_MICS+3). For 4 mics and 37 beams, T = 265.
- Outputs change in the same cycle done is high. The earliest next start is accepted at T+1.
- busy rises in cycle 1 and falls after cycle T.
- spec_addr is stable from cycle 1 until the next accepted start.

## Test plan
- Reset mid-scan: start, then KEY[0]=0 at cycle 100 → cycle 101: busy=0, done never pulses, bnum=doa=best_pwr=0. A fresh start then completes normally with done at T.
- Single-beam match: ROM coef = conj(spectrum phase) for beam 12 only, zero elsewhere; spectra all (1000,0) → bnum=12, doa=-30, best_pwr=(4*1000*coef_re)² computed exactly, done at cycle 265.
- Tie: beams 5 and 20 have equal maximum power → bnum=5, doa=-65.
- Extremes: all spectra and coefs = (-8192,-8192) → no overflow, best_pwr matches the reference model bit-exactly; thresh = best_pwr+1 → no_source=1; thresh = best_pwr → no_source=0.
- Ignored start: start pulsed at cycles 50 and 265 → exactly one done, at 265. No second scan begins until a start is sampled in IDLE.
- Parametrisation: NUM_MICS=8, NUM_BEAMS=19, ANG_STEP=10 → done at cycle 10+19*11=219, doa = -90+10*bnum, coef_addr covers 0..151.

Source files
------------

// File: rtl/beam_scan.sv
// beam_scan: delay-and-sum beam scanner.
// Captures one complex FFT bin per microphone. For every steering beam it
// accumulates coef*spectrum over the channels, squares the magnitude, and
// keeps the strongest beam. It reports beam index, angle, power and a
// below-threshold flag.
//
// Handshake: start is a single-cycle request and is honoured only in IDLE.
// busy is high from the cycle after acceptance through DONE. done pulses
// for one cycle, and in that same cycle bnum/doa/best_pwr/no_source already
// carry the new result. The result outputs hold between done pulses.
module beam_scan #(
   parameter int NUM_MICS  = 4,
   parameter int NUM_BEAMS = 37,
   parameter int DATA_W    = 14,
   parameter int BIN_W     = 10,
   parameter int ANG_START = -90,
   parameter int ANG_STEP  = 5,
   localparam int CH_W    = $clog2(NUM_MICS),
   localparam int BEAM_W  = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1,
   localparam int COEF_AW = $clog2(NUM_BEAMS * NUM_MICS),
   localparam int ACC_W   = 2 * DATA_W + 1 + $clog2(NUM_MICS),
   localparam int PWR_W   = 2 * ACC_W + 1
) (
   input  logic                clk,
   input  logic [3:0]          KEY,
   input  logic                start,
   input  logic [BIN_W-1:0]    maxbin,
   input  logic [PWR_W-1:0]    thresh,
   output logic [BIN_W-1:0]    spec_addr,
   output logic [CH_W-1:0]     spec_ch,
   input  logic [2*DATA_W-1:0] spec_q,
   output logic [COEF_AW-1:0]  coef_addr,
   input  logic [2*DATA_W-1:0] coef_q,
   output logic                busy,
   output logic                done,
   output logic [BEAM_W-1:0]   bnum,
   output logic signed [7:0]   doa,
   output logic [PWR_W-1:0]    best_pwr,
   output logic                no_source,
   output logic [2:0]          dbg_state_o
);

   localparam int CNT_W = $clog2(NUM_MICS + 1);
   localparam int PRD_W = 2 * DATA_W + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ACCUM   = 3'd2,
      S_POWER   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic                     rst_n;
   logic                     unused_key;
   logic [CNT_W-1:0]         cnt_q;
   logic [BEAM_W-1:0]        beam_q;
   logic signed [DATA_W-1:0] buf_re_q [NUM_MICS];
   logic signed [DATA_W-1:0] buf_im_q [NUM_MICS];
   logic signed [ACC_W-1:0]  acc_re_q, acc_im_q, acc_re_d, acc_im_d;
   logic [PWR_W-1:0]         pwr_q, pwr_d;
   logic [PWR_W-1:0]         best_pwr_q, best_pwr_d;
   logic [BEAM_W-1:0]        best_idx_q, best_idx_d;
   logic [BIN_W-1:0]         spec_addr_q;
   logic [BEAM_W-1:0]        bnum_q;
   logic [7:0]               doa_q, doa_d;
   logic [PWR_W-1:0]         best_pwr_out_q;
   logic                     no_source_q, no_source_d;

   logic                     cnt_last, beam_last, take_new;
   logic [CH_W-1:0]          mic_prev;
   logic signed [DATA_W-1:0] cr, ci, sr, si;
   logic signed [PRD_W-1:0]  cr_x, ci_x, sr_x, si_x, prod_re, prod_im;
   logic [2*ACC_W-1:0]       are_x, aim_x, sq_re, sq_im;

   assign rst_n      = KEY[0];
   assign unused_key = ^KEY[3:1];

   // the counter runs 0..NUM_MICS: issue for 0..NUM_MICS-1, last read lands at NUM_MICS
   assign cnt_last  = (cnt_q == CNT_W'(NUM_MICS));
   assign beam_last = (beam_q == BEAM_W'(NUM_BEAMS - 1));
   // read data on the ports belongs to the address issued one cycle earlier
   assign mic_prev  = CH_W'(cnt_q - CNT_W'(1));

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_LOAD;
         S_LOAD:    if (cnt_last) state_d = S_ACCUM;
         S_ACCUM:   if (cnt_last) state_d = S_POWER;
         S_POWER:   state_d = S_COMPARE;
         S_COMPARE: state_d = beam_last ? S_DONE : S_ACCUM;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // state-decoded outputs and memory addresses
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      spec_ch   = '0;
      coef_addr = '0;
      if (state_q == S_LOAD && !cnt_last) spec_ch = CH_W'(cnt_q);
      if (state_q == S_ACCUM && !cnt_last)
         coef_addr = COEF_AW'(int'(beam_q) * NUM_MICS + int'(cnt_q));
   end

   // complex multiply-accumulate, magnitude squared and best-beam selection
   always_comb begin
      cr       = coef_q[2*DATA_W-1:DATA_W];
      ci       = coef_q[DATA_W-1:0];
      sr       = buf_re_q[mic_prev];
      si       = buf_im_q[mic_prev];
      cr_x     = {{(DATA_W+1){cr[DATA_W-1]}}, cr};
      ci_x     = {{(DATA_W+1){ci[DATA_W-1]}}, ci};
      sr_x     = {{(DATA_W+1){sr[DATA_W-1]}}, sr};
      si_x     = {{(DATA_W+1){si[DATA_W-1]}}, si};
      // full-precision product; the result always fits PRD_W bits
      prod_re  = cr_x * sr_x - ci_x * si_x;
      prod_im  = cr_x * si_x + ci_x * sr_x;
      acc_re_d = acc_re_q + {{(ACC_W-PRD_W){prod_re[PRD_W-1]}}, prod_re};
      acc_im_d = acc_im_q + {{(ACC_W-PRD_W){prod_im[PRD_W-1]}}, prod_im};
      // squares are non-negative and well below 2^(2*ACC_W-1), so a
      // truncated multiply of the sign-extended operand is exact
      are_x    = {{ACC_W{acc_re_q[ACC_W-1]}}, acc_re_q};
      aim_x    = {{ACC_W{acc_im_q[ACC_W-1]}}, acc_im_q};
      sq_re    = are_x * are_x;
      sq_im    = aim_x * aim_x;
      pwr_d    = {1'b0, sq_re} + {1'b0, sq_im};
      // strict compare keeps the lower index on a tie; beam 0 always seeds
      take_new    = (beam_q == '0) || (pwr_q > best_pwr_q);
      best_pwr_d  = take_new ? pwr_q : best_pwr_q;
      best_idx_d  = take_new ? beam_q : best_idx_q;
      doa_d       = 8'(ANG_START + ANG_STEP * int'(best_idx_d));
      no_source_d = (best_pwr_d < thresh);
   end

   // datapath registers; result outputs load on the way into DONE so they
   // are already valid in the cycle done is high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         beam_q         <= '0;
         acc_re_q       <= '0;
         acc_im_q       <= '0;
         pwr_q          <= '0;
         best_pwr_q     <= '0;
         best_idx_q     <= '0;
         spec_addr_q    <= '0;
         bnum_q         <= '0;
         doa_q          <= '0;
         best_pwr_out_q <= '0;
         no_source_q    <= 1'b0;
         for (int i = 0; i < NUM_MICS; i++) begin
            buf_re_q[i] <= '0;
            buf_im_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  spec_addr_q <= maxbin;
                  best_pwr_q  <= '0;
                  best_idx_q  <= '0;
                  cnt_q       <= '0;
               end
            end
            S_LOAD: begin
               if (cnt_q != '0) begin
                  buf_re_q[mic_prev] <= spec_q[2*DATA_W-1:DATA_W];
                  buf_im_q[mic_prev] <= spec_q[DATA_W-1:0];
               end
               if (cnt_last) begin
                  cnt_q    <= '0;
                  beam_q   <= '0;
                  acc_re_q <= '0;
                  acc_im_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_ACCUM: begin
               if (cnt_q != '0) begin
                  acc_re_q <= acc_re_d;
                  acc_im_q <= acc_im_d;
               end
               if (cnt_last) cnt_q <= '0;
               else          cnt_q <= cnt_q + CNT_W'(1);
            end
            S_POWER: begin
               pwr_q <= pwr_d;
            end
            S_COMPARE: begin
               best_pwr_q <= best_pwr_d;
               best_idx_q <= best_idx_d;
               if (beam_last) begin
                  bnum_q         <= best_idx_d;
                  doa_q          <= doa_d;
                  best_pwr_out_q <= best_pwr_d;
                  no_source_q    <= no_source_d;
               end else begin
                  beam_q   <= beam_q + BEAM_W'(1);
                  acc_re_q <= '0;
                  acc_im_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign spec_addr   = spec_addr_q;
   assign bnum        = bnum_q;
   assign doa         = doa_q;
   assign best_pwr    = best_pwr_out_q;
   assign no_source   = no_source_q;
   assign dbg_state_o = state_q;

endmodule
